// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter that shares one FIFO write port among NUM_SRC
// AXI-Stream sources; never writes while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         i_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0]  i_tdata,
    input  logic [NUM_SRC-1:0]         i_tlast,
    output logic [NUM_SRC-1:0]         o_tready,
    output logic                       o_wen,
    output logic [DATA_W-1:0]          o_wdata,
    output logic                       o_wlast,
    input  logic                       i_wfull,
    output logic [NUM_SRC-1:0]         o_grant,
    output logic [$clog2(NUM_SRC)-1:0] o_src_id,
    output logic                       o_pkt_done,
    output logic [LEN_W-1:0]           o_pkt_len,
    output logic                       dbg_state
);

    localparam int SRC_W = $clog2(NUM_SRC);

    // Handshake: a beat moves on a cycle where tvalid[k] and tready[k] are both high;
    // that same cycle o_wen is high and the beat is written into the FIFO.
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [SRC_W-1:0] last;
    logic [SRC_W-1:0] winner;
    logic             any_req;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_inc;
    logic             sel_valid;
    logic             beat_done;

    // Iterate the search order backwards so the first requester after 'last' wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (i_tvalid[(int'(last) + i) % NUM_SRC]) begin
                winner  = SRC_W'((int'(last) + i) % NUM_SRC);
                any_req = 1'b1;
            end
        end
    end

    assign sel_valid = i_tvalid[o_src_id];
    assign o_wen     = (state == LOCKED) & sel_valid & ~i_wfull;
    assign o_tready  = (state == LOCKED && !i_wfull) ? o_grant : '0;
    assign o_wdata   = i_tdata[int'(o_src_id)*DATA_W +: DATA_W];
    assign o_wlast   = i_tlast[o_src_id];
    assign beat_done = o_wen & o_wlast;
    assign cnt_inc   = (&cnt) ? cnt : cnt + LEN_W'(1);
    assign dbg_state = (state == LOCKED);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = LOCKED;
            LOCKED:  if (beat_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            o_grant    <= '0;
            o_src_id   <= '0;
            last       <= SRC_W'(NUM_SRC - 1);
            cnt        <= '0;
            o_pkt_done <= 1'b0;
            o_pkt_len  <= '0;
        end else begin
            state      <= state_nxt;
            o_pkt_done <= beat_done;
            if (state == IDLE && any_req) begin
                o_grant  <= {{(NUM_SRC-1){1'b0}}, 1'b1} << winner;
                o_src_id <= winner;
                last     <= winner;
            end
            if (o_wen) begin
                if (o_wlast) begin
                    cnt       <= '0;
                    o_pkt_len <= cnt_inc;
                    o_grant   <= '0;
                    o_src_id  <= '0;
                end else begin
                    cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-source expected beat queues plus a
// small arbitration model that predicts grant, ready, write enable and packet reports.
module tb_fifo_wr_arbiter;
  localparam int NUM_SRC = 4;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 3;
  localparam int SRC_W   = $clog2(NUM_SRC);
  localparam int MAXL    = (1 << LEN_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_SRC-1:0]        i_tvalid;
  logic [NUM_SRC*DATA_W-1:0] i_tdata;
  logic [NUM_SRC-1:0]        i_tlast;
  logic [NUM_SRC-1:0]        o_tready;
  logic                      o_wen;
  logic [DATA_W-1:0]         o_wdata;
  logic                      o_wlast;
  logic                      i_wfull;
  logic [NUM_SRC-1:0]        o_grant;
  logic [SRC_W-1:0]          o_src_id;
  logic                      o_pkt_done;
  logic [LEN_W-1:0]          o_pkt_len;
  logic                      dbg_state;

  fifo_wr_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .i_tvalid(i_tvalid), .i_tdata(i_tdata), .i_tlast(i_tlast),
    .o_tready(o_tready), .o_wen(o_wen), .o_wdata(o_wdata), .o_wlast(o_wlast),
    .i_wfull(i_wfull), .o_grant(o_grant), .o_src_id(o_src_id), .o_pkt_done(o_pkt_done),
    .o_pkt_len(o_pkt_len), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [DATA_W:0]    drv_q [NUM_SRC][$];
  logic [DATA_W:0]    exp_q [NUM_SRC][$];
  logic [NUM_SRC-1:0] gate;
  logic [NUM_SRC-1:0] acc;
  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  bit m_locked;
  int m_src, m_last, beats, pend_len;
  bit pend_done;
  int wait_cnt [NUM_SRC];
  int grant_log[$];
  int len_log[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_inputs();
    for (int k = 0; k < NUM_SRC; k++) begin
      if (drv_q[k].size() > 0 && !gate[k]) begin
        i_tvalid[k]                = 1'b1;
        i_tdata[k*DATA_W +: DATA_W] = drv_q[k][0][DATA_W-1:0];
        i_tlast[k]                 = drv_q[k][0][DATA_W];
      end else begin
        i_tvalid[k]                = 1'b0;
        i_tdata[k*DATA_W +: DATA_W] = '0;
        i_tlast[k]                 = 1'b0;
      end
    end
  endtask

  task automatic push_pkt(input int k, input int len);
    logic [DATA_W:0] beat;
    for (int b = 0; b < len; b++) begin
      beat = {(b == len - 1) ? 1'b1 : 1'b0, DATA_W'($urandom)};
      drv_q[k].push_back(beat);
      exp_q[k].push_back(beat);
    end
  endtask

  task automatic monitor();
    bit exp_wen;
    int s, w;
    logic [DATA_W:0] e;
    exp_wen = m_locked && i_tvalid[m_src] && !i_wfull;
    chk("grant", 64'(o_grant), m_locked ? 64'(1 << m_src) : 64'd0);
    chk("src_id", 64'(o_src_id), m_locked ? 64'(m_src) : 64'd0);
    chk("wen", 64'(o_wen), 64'(exp_wen));
    chk("tready", 64'(o_tready), (m_locked && !i_wfull) ? 64'(1 << m_src) : 64'd0);
    chk("wen_while_full", 64'(o_wen & i_wfull), 64'd0);
    chk("pkt_done", 64'(o_pkt_done), 64'(pend_done));
    if (pend_done) begin
      chk("pkt_len", 64'(o_pkt_len), 64'(pend_len));
      len_log.push_back(int'(o_pkt_len));
    end
    pend_done = 1'b0;
    acc = i_tvalid & o_tready;
    if (o_wen) begin
      n_wr++;
      s = int'(o_src_id);
      chk("wdata_avail", 64'(exp_q[s].size() > 0), 64'd1);
      if (exp_q[s].size() > 0) begin
        e = exp_q[s].pop_front();
        chk("wbeat", 64'({o_wlast, o_wdata}), 64'(e));
      end
    end
    if (m_locked) begin
      if (exp_wen) begin
        beats++;
        if (i_tlast[m_src]) begin
          pend_done = 1'b1;
          pend_len  = (beats > MAXL) ? MAXL : beats;
          beats     = 0;
          m_locked  = 1'b0;
        end
      end
    end else begin
      w = -1;
      for (int i = 1; i <= NUM_SRC; i++)
        if (w < 0 && i_tvalid[(m_last + i) % NUM_SRC]) w = (m_last + i) % NUM_SRC;
      if (w >= 0) begin
        chk("no_starve", 64'(wait_cnt[w] <= NUM_SRC - 1), 64'd1);
        for (int k = 0; k < NUM_SRC; k++)
          if (k == w) wait_cnt[k] = 0;
          else if (i_tvalid[k]) wait_cnt[k]++;
        grant_log.push_back(w);
        m_src = w; m_last = w; m_locked = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!rst) monitor();
    @(posedge clk);
    #1;
    for (int k = 0; k < NUM_SRC; k++)
      if (acc[k] && drv_q[k].size() > 0) void'(drv_q[k].pop_front());
    acc = '0;
    drive_inputs();
  endtask

  function automatic bit busy();
    busy = m_locked || pend_done;
    for (int k = 0; k < NUM_SRC; k++) if (drv_q[k].size() > 0) busy = 1'b1;
  endfunction

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy() && n < budget) begin cycle(); n++; end
    chk("drain_in_budget", 64'(busy()), 64'd0);
  endtask

  task automatic wait_writes(input int count, input int budget);
    int target = n_wr + count;
    int n = 0;
    while (n_wr < target && n < budget) begin cycle(); n++; end
    chk("writes_in_budget", 64'(n_wr >= target), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin drv_q[k].delete(); exp_q[k].delete(); wait_cnt[k] = 0; end
    gate = '0; i_wfull = 1'b0; acc = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_locked = 1'b0; m_src = 0; m_last = NUM_SRC - 1; beats = 0; pend_done = 1'b0; pend_len = 0;
  endtask

  initial begin
    int nw;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    i_tvalid = '0; i_tdata = '0; i_tlast = '0; i_wfull = 1'b0; gate = '0; rst = 1'b1;
    @(posedge clk); #1;
    do_reset();
    chk("rst_grant", 64'(o_grant), 64'd0);
    chk("rst_src_id", 64'(o_src_id), 64'd0);
    chk("rst_pkt_done", 64'(o_pkt_done), 64'd0);
    chk("rst_pkt_len", 64'(o_pkt_len), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_tready", 64'(o_tready), 64'd0);

    // all sources with single-beat packets: round-robin from source 0
    grant_log.delete(); len_log.delete();
    push_pkt(0, 1); push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1); push_pkt(3, 1);
    drive_inputs();
    run_until_idle(100);
    chk("rr_count", 64'(grant_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("rr_order", 64'(grant_log[i]), 64'(exp_order[i]));
    for (int i = 0; i < len_log.size(); i++) chk("rr_len", 64'(len_log[i]), 64'd1);

    // src1 5-beat packet, src2 requests mid-packet
    grant_log.delete(); len_log.delete();
    push_pkt(1, 5); drive_inputs();
    wait_writes(1, 20);
    push_pkt(2, 2); drive_inputs();
    run_until_idle(100);
    chk("mid_req_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) begin
      chk("mid_req_first", 64'(grant_log[0]), 64'd1);
      chk("mid_req_second", 64'(grant_log[1]), 64'd2);
    end
    chk("mid_req_len5", 64'(len_log.size() > 0 ? len_log[0] : -1), 64'd5);

    // FIFO full for 3 cycles mid-packet
    push_pkt(3, 6); drive_inputs();
    wait_writes(2, 20);
    i_wfull = 1'b1;
    nw = n_wr;
    repeat (3) cycle();
    chk("full_no_write", 64'(n_wr - nw), 64'd0);
    chk("full_grant_held", 64'(o_grant), 64'b1000);
    i_wfull = 1'b0;
    run_until_idle(100);

    // granted source drops tvalid for 4 cycles; 9-beat packet saturates the length
    len_log.delete();
    push_pkt(2, 4); push_pkt(3, 9); drive_inputs();
    wait_writes(2, 20);
    gate[2] = 1'b1; drive_inputs();
    nw = n_wr;
    repeat (4) cycle();
    chk("drop_no_write", 64'(n_wr - nw), 64'd0);
    chk("drop_grant_held", 64'(o_grant), 64'b0100);
    gate = '0; drive_inputs();
    run_until_idle(100);
    chk("drop_len_count", 64'(len_log.size()), 64'd2);
    if (len_log.size() == 2) begin
      chk("drop_len4", 64'(len_log[0]), 64'd4);
      chk("sat_len", 64'(len_log[1]), 64'(MAXL));
    end

    // reset mid-packet restores the round-robin pointer
    push_pkt(0, 6); drive_inputs();
    wait_writes(2, 20);
    do_reset();
    chk("midrst_grant", 64'(o_grant), 64'd0);
    chk("midrst_state", 64'(dbg_state), 64'd0);
    grant_log.delete();
    push_pkt(0, 1); push_pkt(1, 1); drive_inputs();
    run_until_idle(50);
    chk("midrst_first", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'd0);

    // random traffic, random full and source stalls
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(0, NUM_SRC - 1);
        if (drv_q[k].size() < 12) push_pkt(k, $urandom_range(1, 10));
      end
      i_wfull = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < NUM_SRC; k++) gate[k] = ($urandom_range(0, 6) == 0);
      drive_inputs();
      cycle();
    end
    gate = '0; i_wfull = 1'b0; drive_inputs();
    run_until_idle(2000);
    for (int k = 0; k < NUM_SRC; k++) chk("sb_empty", 64'(exp_q[k].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
